// File: rtl/spu_vector_distance_if.sv
// Handshake/data bundle for the streaming vector-distance engine.
// The slave modport is the engine's view; the master modport is the producer/consumer view.
interface spu_vector_distance_if #(
  parameter int DIM = 4,
  parameter int W   = 8
);
  localparam int OW = 2*W + $clog2(DIM);
  localparam int CW = $clog2(DIM+1);

  logic          clear;
  logic [1:0]    mode;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_dist;
  logic [1:0]    out_mode;
  logic [CW-1:0] elem_cnt;

  modport slave (
    input  clear, mode, in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_dist, out_mode, elem_cnt
  );

  modport master (
    output clear, mode, in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_dist, out_mode, elem_cnt
  );
endinterface

// File: rtl/spu_vector_distance.sv
// Streaming distance engine: accepts DIM element pairs one per handshake and
// emits a Manhattan / Chebyshev / squared-Euclidean / Hamming distance per pair.
// The result width OW covers the worst case of every metric, so nothing wraps.
module spu_vector_distance #(
  parameter int DIM = 4,
  parameter int W   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spu_vector_distance_if.slave  bus
);
  localparam int OW = 2*W + $clog2(DIM);
  localparam int CW = $clog2(DIM+1);

  localparam logic [1:0] MODE_MANH = 2'b00;
  localparam logic [1:0] MODE_CHEB = 2'b01;
  localparam logic [1:0] MODE_SQE  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    HOLD  = 2'b10
  } state_t;

  state_t        state_reg, state_next;
  logic [OW-1:0] acc_reg, acc_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]    mode_reg, mode_next;
  logic [OW-1:0] dist_reg, dist_next;
  logic [1:0]    out_mode_reg, out_mode_next;
  logic          valid_reg;
  logic          ready_reg;

  logic [W-1:0]  diff;
  logic [1:0]    mode_eff;
  logic [OW-1:0] acc_base;
  logic [OW-1:0] acc_fold;
  logic          accept;
  logic          last_elem;

  // Fold one element distance into the running accumulator for the given metric.
  function automatic logic [OW-1:0] fold(input logic [1:0] m,
                                         input logic [OW-1:0] acc,
                                         input logic [W-1:0] d);
    logic [OW-1:0] dx;
    dx = OW'(d);
    case (m)
      MODE_MANH: fold = acc + dx;
      MODE_CHEB: fold = (dx > acc) ? dx : acc;
      MODE_SQE:  fold = acc + dx * dx;
      default:   fold = acc + {{(OW-1){1'b0}}, (d != '0)};
    endcase
  endfunction

  // Element distance and the accumulator contribution for the current beat.
  // The first element starts from zero with the live mode, so the fold
  // result is exactly that element's own value; later elements use the latched mode.
  always_comb begin
    diff      = (bus.in_a >= bus.in_b) ? (bus.in_a - bus.in_b) : (bus.in_b - bus.in_a);
    mode_eff  = (state_reg == IDLE) ? bus.mode : mode_reg;
    acc_base  = (state_reg == IDLE) ? '0 : acc_reg;
    acc_fold  = fold(mode_eff, acc_base, diff);
    accept    = bus.in_valid && ready_reg;
    last_elem = (cnt_reg == CW'(DIM-1));
  end

  // Next-state and datapath control; clear overrides any handshake this cycle.
  always_comb begin
    state_next    = state_reg;
    acc_next      = acc_reg;
    cnt_next      = cnt_reg;
    mode_next     = mode_reg;
    dist_next     = dist_reg;
    out_mode_next = out_mode_reg;

    if (bus.clear) begin
      state_next = IDLE;
      acc_next   = '0;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            acc_next   = acc_fold;
            mode_next  = bus.mode;
            cnt_next   = CW'(1);
            state_next = ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_next = acc_fold;
            cnt_next = cnt_reg + CW'(1);
            if (last_elem) begin
              state_next    = HOLD;
              dist_next     = acc_fold;
              out_mode_next = mode_reg;
            end
          end
        end
        HOLD: begin
          if (valid_reg && bus.out_ready) begin
            state_next = IDLE;
            acc_next   = '0;
            cnt_next   = '0;
          end
        end
        default: begin
          state_next = IDLE;
          acc_next   = '0;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // State, accumulator and result registers; reset discards any partial vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      mode_reg     <= '0;
      dist_reg     <= '0;
      out_mode_reg <= '0;
    end else begin
      state_reg    <= state_next;
      acc_reg      <= acc_next;
      cnt_reg      <= cnt_next;
      mode_reg     <= mode_next;
      dist_reg     <= dist_next;
      out_mode_reg <= out_mode_next;
    end
  end

  // Handshake flags registered from the next state so they never see inputs
  // combinationally; ready stays low while in reset and rises on the first edge after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      ready_reg <= 1'b0;
    end else begin
      valid_reg <= (state_next == HOLD);
      ready_reg <= (state_next != HOLD);
    end
  end

  assign bus.in_ready  = ready_reg;
  assign bus.out_valid = valid_reg;
  assign bus.out_dist  = dist_reg;
  assign bus.out_mode  = out_mode_reg;
  assign bus.elem_cnt  = cnt_reg;

endmodule

// File: doc/spu_vector_distance.md
# spu_vector_distance

Parametrised streaming distance engine, the next generation of the SPU's fixed 4-bit Manhattan-distance datapath. Accepts a vector pair one element per handshake and accumulates DIM elements. Emits one selectable distance metric per pair: Manhattan, Chebyshev, squared Euclidean or Hamming. Sits between the SPU input-unpacking logic and the result output register, with valid/ready flow control on both sides.

## Interface
- DIM, 4: elements per vector; must be ≥ 2.
- W, 8: unsigned element width in bits.
- OW (localparam), 2*W + $clog2(DIM): result width; holds the worst case of every mode without overflow.

- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- clear  in  1  synchronous abort of the current vector.
- mode  in  2  metric: 00 Manhattan, 01 Chebyshev, 10 squared Euclidean, 11 Hamming; sampled on element 0 only.
- in_valid  in  1  element pair present.
- in_ready  out  1  block accepts element pair.
- in_a  in  W  element of vector A, unsigned.
- in_b  in  W  element of vector B, unsigned.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes result.
- out_dist  out  OW  result, zero-extended.
- out_mode  out  2  mode the result was computed with.
- elem_cnt  out  clog2(DIM+1)  elements accepted for the current vector.

## Operation
- States:
  - IDLE: no vector in progress, elem_cnt = 0.
  - ACCUM: 1 ≤ elem_cnt < DIM.
  - HOLD: result valid.
- Accept: element is taken when in_valid && in_ready. in_ready = 1 in IDLE and ACCUM, 0 in HOLD.
- Per element: d = |in_a − in_b|, computed at W bits unsigned; no sign wrap.
- Accumulator update per mode:
  - Manhattan: acc += d.
  - Chebyshev: acc = max(acc, d).
  - Squared Euclidean: acc += d*d.
  - Hamming: acc += (d != 0).
- First element (IDLE accept):
  - acc loads the single-element value, not acc plus contribution.
  - mode is latched; mode input changes mid-vector are ignored.
  - State goes to ACCUM, or straight to HOLD if DIM = 1 (not a legal configuration; DIM ≥ 2).
- DIM-th accept: out_dist ← final acc, state → HOLD, out_valid = 1.
- HOLD:
  - out_dist and out_mode are stable until out_valid && out_ready.
  - On that handshake: state → IDLE, elem_cnt → 0.
- clear: next state is IDLE, elem_cnt = 0, out_valid = 0, acc = 0. Applies in any state, including HOLD, where the pending result is discarded.
- clear and an input handshake in the same cycle: clear wins and the element is dropped.
- No overflow is possible by the OW construction; arithmetic is never truncated.

## Timing
- Reset values (asynchronous, immediate on rst_n low): state IDLE, in_ready 1 after reset release (0 while rst_n low), out_valid 0, out_dist 0, out_mode 00, elem_cnt 0, acc 0.
- Reset mid-vector or mid-HOLD discards everything; there is no partial output.
- Latency: out_valid rises on the clock edge that accepts the DIM-th element, so it is visible the cycle after that handshake.
- Throughput with out_ready held high: one result per DIM+1 cycles (DIM accept cycles plus one HOLD cycle).
- in_a, in_b and mode are sampled only on accept edges. Values while in_ready = 0 are ignored.
- out_* are registered outputs with no combinational path from inputs. in_ready depends only on state.

## Test plan
- Manhattan, DIM=4, W=8: a={10,0,255,7}, b={3,5,0,7}, mode=00, out_ready=1 → out_dist=267 and out_valid=1 exactly one cycle after the 4th accept; out_mode=00.
- Chebyshev with the same vectors, mode=01 → 255. Hamming, mode=11 → 3.
- Squared Euclidean: a={1,2,3,4}, b={4,6,3,0} → 41. Worst case a all 255, b all 0 → 260100, which fits in 18-bit OW.
- Backpressure: out_ready=0 for 5 cycles after the result → out_valid, out_dist and out_mode stable, in_ready=0, toggling in_valid has no effect. Then out_ready=1 → IDLE the next cycle, with elem_cnt=0 and in_ready=1.
- Mode switch: mode=01 on element 0, changed to 00 for elements 1–3 → Chebyshev result, out_mode=01.
- Abort: clear asserted together with the 3rd element's handshake, then a fresh Manhattan vector {1,1,1,1} vs {0,0,0,0} → out_dist=4 (no residue). A repeat run with rst_n pulsed low after element 2 → all outputs 0 immediately, and the next full vector gives the correct result.
